// File: rtl/kyber_host_io.sv
// Host streaming port for the Kyber core: deserializes a W-bit valid/ready stream
// into the coder operand buses, and serializes a snapshotted coder result back out.
module kyber_host_io #(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_start,
  input  logic             rx_op,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [W-1:0]     rx_data,
  output logic             rx_busy,
  output logic [6399:0]    pk_in,
  output logic [255:0]     m_in,
  output logic [6143:0]    sk_in,
  output logic [6143:0]    c_in,
  output logic             load_input_Enc,
  output logic             load_input_Dec,
  input  logic             tx_start,
  input  logic [1:0]       tx_op,
  input  logic [6399:0]    pk_out,
  input  logic [6143:0]    sk_out,
  input  logic [6143:0]    c_out,
  input  logic [255:0]     m_out,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [W-1:0]     tx_data,
  output logic             tx_last,
  output logic             tx_busy
);
  localparam int NPK   = 6400 / W;
  localparam int NSK   = 6144 / W;
  localparam int NC    = 6144 / W;
  localparam int NM    = 256 / W;
  localparam int ENC_N = NPK + NM;
  localparam int DEC_N = NC + NSK;
  localparam int IW    = $clog2(DEC_N + 1);
  localparam int TW    = $clog2(NPK + 1);

  localparam logic [1:0] RX_IDLE = 2'd0;
  localparam logic [1:0] RX_RECV = 2'd1;
  localparam logic [1:0] RX_LOAD = 2'd2;
  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

  // ---------------- receive path ----------------
  logic [1:0]    rx_state;
  logic          rx_op_q;
  logic [IW-1:0] rx_idx;
  logic          rx_fire;
  logic          rx_final;

  assign rx_ready       = (rx_state == RX_RECV);
  assign rx_busy        = (rx_state != RX_IDLE);
  assign rx_fire        = rx_ready && rx_valid;
  assign rx_final       = (rx_idx == (rx_op_q ? IW'(DEC_N - 1) : IW'(ENC_N - 1)));
  assign load_input_Enc = (rx_state == RX_LOAD) && !rx_op_q;
  assign load_input_Dec = (rx_state == RX_LOAD) &&  rx_op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_op_q  <= 1'b0;
      rx_idx   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_start) begin
          rx_op_q  <= rx_op;
          rx_idx   <= '0;
          rx_state <= RX_RECV;
        end
        RX_RECV: if (rx_fire) begin
          rx_idx <= rx_idx + IW'(1);
          if (rx_final) rx_state <= RX_LOAD;
        end
        RX_LOAD: rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Word index selects both the target bus and the slot; the first bus of each op
  // occupies the low indices, the second bus follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pk_in <= '0;
      m_in  <= '0;
      sk_in <= '0;
      c_in  <= '0;
    end else if (rx_fire) begin
      if (!rx_op_q) begin
        for (int k = 0; k < NPK; k++)
          if (rx_idx == IW'(k)) pk_in[k*W +: W] <= rx_data;
        for (int k = 0; k < NM; k++)
          if (rx_idx == IW'(NPK + k)) m_in[k*W +: W] <= rx_data;
      end else begin
        for (int k = 0; k < NC; k++)
          if (rx_idx == IW'(k)) c_in[k*W +: W] <= rx_data;
        for (int k = 0; k < NSK; k++)
          if (rx_idx == IW'(NC + k)) sk_in[k*W +: W] <= rx_data;
      end
    end
  end

  // ---------------- transmit path ----------------
  logic [0:0]    tx_state;
  logic [6399:0] snap;
  logic [TW-1:0] tx_rem;

  assign tx_valid = (tx_state == TX_SEND);
  assign tx_busy  = tx_valid;
  assign tx_data  = tx_valid ? snap[W-1:0] : '0;
  assign tx_last  = tx_valid && (tx_rem == TW'(1));

  // The snapshot decouples the stream from the coder buses after tx_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      snap     <= '0;
      tx_rem   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: if (tx_start) begin
          case (tx_op)
            2'd0:    begin snap <= pk_out;                 tx_rem <= TW'(NPK); end
            2'd1:    begin snap <= {256'd0, sk_out};       tx_rem <= TW'(NSK); end
            2'd2:    begin snap <= {256'd0, c_out};        tx_rem <= TW'(NC);  end
            default: begin snap <= {6144'd0, m_out};       tx_rem <= TW'(NM);  end
          endcase
          tx_state <= TX_SEND;
        end
        TX_SEND: if (tx_ready) begin
          snap   <= snap >> W;
          tx_rem <= tx_rem - TW'(1);
          if (tx_rem == TW'(1)) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_kyber_host_io.sv
// Scoreboarded bench for kyber_host_io: drivers push expectations, a negedge
// monitor pops them whenever a load strobe or a tx transfer is presented.
module tb_kyber_host_io;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_start, rx_op, rx_valid, rx_ready, rx_busy;
  logic [W-1:0]  rx_data;
  logic [6399:0] pk_in;
  logic [255:0]  m_in;
  logic [6143:0] sk_in, c_in;
  logic          load_input_Enc, load_input_Dec;
  logic          tx_start;
  logic [1:0]    tx_op;
  logic [6399:0] pk_out;
  logic [6143:0] sk_out, c_out;
  logic [255:0]  m_out;
  logic          tx_valid, tx_ready, tx_last, tx_busy;
  logic [W-1:0]  tx_data;

  kyber_host_io #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .rx_start(rx_start), .rx_op(rx_op), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_busy(rx_busy),
    .pk_in(pk_in), .m_in(m_in), .sk_in(sk_in), .c_in(c_in),
    .load_input_Enc(load_input_Enc), .load_input_Dec(load_input_Dec),
    .tx_start(tx_start), .tx_op(tx_op),
    .pk_out(pk_out), .sk_out(sk_out), .c_out(c_out), .m_out(m_out),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          op;
    logic [6399:0] pk;
    logic [255:0]  m;
    logic [6143:0] sk;
    logic [6143:0] c;
  } ld_t;
  typedef struct packed { logic [31:0] d; logic l; } txe_t;

  ld_t  ld_q[$];
  txe_t tx_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference view of the operand buses, built from words as they are issued.
  logic [6399:0] m_pk;
  logic [255:0]  m_m;
  logic [6143:0] m_sk, m_c;
  logic [31:0]   rx_words[$];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_bus(input string nm, input logic [6399:0] a, input logic [6399:0] e);
    checks++;
    if (a !== e) begin
      int i;
      errors++;
      i = 0;
      while (i < 199 && a[i*32 +: 32] === e[i*32 +: 32]) i++;
      $display("FAIL %s word %0d got %h want %h", nm, i, a[i*32 +: 32], e[i*32 +: 32]);
    end
  endtask

  task automatic rand_bus(output logic [6399:0] b);
    for (int i = 0; i < 200; i++) b[i*32 +: 32] = $urandom;
  endtask

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  initial begin
    ld_t  e;
    txe_t t;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && tx_valid) begin
          chk("tx_hold_data", tx_data, prev_d);
          chk("tx_hold_last", tx_last, prev_l);
        end
        prev_stall = tx_valid && !tx_ready;
        prev_d     = tx_data;
        prev_l     = tx_last;
        if (tx_valid && tx_ready) begin
          if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected got %h want no word", tx_data);
          end else begin
            t = tx_q.pop_front();
            chk("tx_data", tx_data, t.d);
            chk("tx_last", tx_last, t.l);
          end
        end
        if (load_input_Enc || load_input_Dec) begin
          if (ld_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL load_unexpected got enc=%b dec=%b want none", load_input_Enc, load_input_Dec);
          end else begin
            e = ld_q.pop_front();
            chk("load_enc", load_input_Enc, !e.op);
            chk("load_dec", load_input_Dec, e.op);
            chk_bus("pk_in", pk_in, e.pk);
            chk_bus("m_in", m_in, e.m);
            chk_bus("sk_in", sk_in, e.sk);
            chk_bus("c_in", c_in, e.c);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic rx_load(input logic op, input int n, input bit toggle, input int abort_at, input bit poke);
    int k = 0, cyc = 0;
    bit acc;
    @(posedge clk); #1 rx_start = 1'b1; rx_op = op;
    @(posedge clk); #1 rx_start = 1'b0;
    while (k < n && cyc < 4000) begin
      if (abort_at >= 0 && k == abort_at) break;
      rx_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      rx_data  = rx_words[k];
      rx_start = poke && (cyc == 20);
      rx_op    = ~op;
      @(negedge clk);
      if (cyc == 0) chk("rx_busy_on", rx_busy, 1);
      acc = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    rx_valid = 1'b0;
    rx_start = 1'b0;
    if (abort_at >= 0) return;
    chk("rx_words_accepted", k, n);
    if (k == n) begin
      for (int i = 0; i < n; i++) begin
        if (!op) begin
          if (i < 200) m_pk[i*32 +: 32] = rx_words[i];
          else         m_m[(i-200)*32 +: 32] = rx_words[i];
        end else begin
          if (i < 192) m_c[i*32 +: 32] = rx_words[i];
          else         m_sk[(i-192)*32 +: 32] = rx_words[i];
        end
      end
      ld_q.push_back('{op, m_pk, m_m, m_sk, m_c});
    end
    @(negedge clk);
    chk("load_strobe_timing", op ? load_input_Dec : load_input_Enc, 1);
    chk("load_other_low", op ? load_input_Enc : load_input_Dec, 0);
    @(negedge clk);
    chk("load_one_cycle", load_input_Enc | load_input_Dec, 0);
    chk("rx_ready_idle", rx_ready, 0);
    chk("rx_busy_idle", rx_busy, 0);
  endtask

  task automatic tx_xfer(input logic [1:0] op, input int mode, input bit change, input bit poke);
    logic [6399:0] b;
    int n, cyc = 0;
    case (op)
      2'd0:    begin b = pk_out;           n = 200; end
      2'd1:    begin b = {256'd0, sk_out}; n = 192; end
      2'd2:    begin b = {256'd0, c_out};  n = 192; end
      default: begin b = {6144'd0, m_out}; n = 8;   end
    endcase
    @(posedge clk); #1 tx_start = 1'b1; tx_op = op;
    for (int k = 0; k < n; k++) tx_q.push_back('{b[k*32 +: 32], k == n - 1});
    @(posedge clk); #1 tx_start = 1'b0;
    if (change) pk_out = ~pk_out;
    while (tx_q.size() > 0 && cyc < 4000) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ($urandom_range(0, 3) != 0);
        default: tx_ready = !(cyc >= 4 && cyc < 9);
      endcase
      tx_start = poke && (cyc == 10);
      tx_op    = op + 2'd1;
      @(posedge clk); #1;
      cyc++;
    end
    tx_ready = 1'b0;
    tx_start = 1'b0;
    chk("tx_words_left", tx_q.size(), 0);
    @(negedge clk);
    chk("tx_busy_idle", tx_busy, 0);
    chk("tx_valid_idle", tx_valid, 0);
    chk("tx_data_idle", tx_data, 0);
    chk("tx_last_idle", tx_last, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; rx_start = 0; rx_op = 0; rx_valid = 0; rx_data = '0;
    tx_start = 0; tx_op = '0; tx_ready = 0;
    pk_out = '0; sk_out = '0; c_out = '0; m_out = '0;
    m_pk = '0; m_m = '0; m_sk = '0; m_c = '0;
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_rx_busy", rx_busy, 0);
    chk("rst_loads", {load_input_Enc, load_input_Dec}, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_busy", tx_busy, 0);
    chk_bus("rst_pk_in", pk_in, '0);
    chk_bus("rst_c_in", c_in, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Enc load, word k = k
    rx_words.delete();
    for (int k = 0; k < 208; k++) rx_words.push_back(k);
    rx_load(1'b0, 208, 1'b0, -1, 1'b0);
    chk("enc_pk_lo", pk_in[31:0], 0);
    chk("enc_pk_hi", pk_in[6399:6368], 199);
    chk("enc_m_lo", m_in[31:0], 200);
    chk("enc_m_hi", m_in[255:224], 207);
    chk_bus("enc_sk_untouched", sk_in, '0);
    chk_bus("enc_c_untouched", c_in, '0);

    // Dec load, rx_valid toggling
    rx_words.delete();
    for (int k = 0; k < 384; k++) rx_words.push_back(32'hA5A5_0000 | k);
    rx_load(1'b1, 384, 1'b1, -1, 1'b0);
    chk("dec_c_hi", c_in[6143:6112], 32'hA5A5_00BF);
    chk("dec_sk_lo", sk_in[31:0], 32'hA5A5_00C0);
    chk_bus("dec_pk_held", pk_in, m_pk);

    // TX m with a 5-cycle stall mid-stream
    for (int k = 0; k < 32; k++) m_out[k*8 +: 8] = 8'(k);
    tx_xfer(2'd3, 2, 1'b0, 1'b0);

    // TX pk with pk_out changing after tx_start; TX sk with random ready
    rand_bus(pk_out);
    tx_xfer(2'd0, 0, 1'b1, 1'b0);
    begin
      logic [6399:0] r;
      rand_bus(r);
      sk_out = r[6143:0];
    end
    tx_xfer(2'd1, 1, 1'b0, 1'b0);

    // Reset after 50 Enc words, then a fresh load
    rx_words.delete();
    for (int k = 0; k < 208; k++) rx_words.push_back($urandom);
    rx_load(1'b0, 208, 1'b0, 50, 1'b0);
    rst = 1'b1;
    m_pk = '0; m_m = '0; m_sk = '0; m_c = '0;
    @(negedge clk);
    chk("abort_loads", {load_input_Enc, load_input_Dec}, 0);
    chk("abort_rx_ready", rx_ready, 0);
    chk("abort_rx_busy", rx_busy, 0);
    chk_bus("abort_pk_in", pk_in, '0);
    chk_bus("abort_sk_in", sk_in, '0);
    chk("abort_tx_valid", tx_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    rx_load(1'b0, 208, 1'b0, -1, 1'b0);

    // Full duplex with ignored restarts on both paths
    rx_words.delete();
    for (int k = 0; k < 384; k++) rx_words.push_back($urandom);
    begin
      logic [6399:0] r;
      rand_bus(r);
      c_out = r[6143:0];
    end
    fork
      rx_load(1'b1, 384, 1'b0, -1, 1'b1);
      tx_xfer(2'd2, 1, 1'b0, 1'b1);
    join

    repeat (3) @(posedge clk);
    chk("ld_q_drained", ld_q.size(), 0);
    chk("tx_q_drained", tx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
